// File: rtl/urv_dm_pkg.sv
// Shared types and constants for the uRV data-memory arbiter.
package urv_dm_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Load data handed back when the slave never acknowledges.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Watchdog counter width; TIMEOUT is limited to 255.
  localparam int CNT_W = 8;

  // One latched slave transfer.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
  } xfer_t;

endpackage

// File: rtl/urv_rr_arb2.sv
// Combinational two-way round-robin pick. The requester that was not
// granted last wins a tie; a lone requester always wins.
module urv_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,   // 1 = requester 1 was granted most recently
  output logic valid,
  output logic sel     // 1 = requester 1 wins
);

  // Pick the winner from the two requests and the last-granted bit.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      sel = ~last;
    end else begin
      sel = req1;
    end
  end

endmodule

// File: rtl/urv_dm_arbiter.sv
// Two-master arbiter for the uRV shared data-memory slave port.
// One transfer is outstanding at a time: IDLE picks a master and latches
// its request, BUSY holds the slave request until ack or watchdog expiry,
// DONE pulses the completion strobe and advances the round-robin pointer.
module urv_dm_arbiter
  import urv_dm_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_s_i,
  input  logic [3:0]  m0_select_i,
  input  logic        m0_store_i,
  input  logic        m0_load_i,
  output logic [31:0] m0_data_l_o,
  output logic        m0_load_done_o,
  output logic        m0_store_done_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_s_i,
  input  logic [3:0]  m1_select_i,
  input  logic        m1_store_i,
  input  logic        m1_load_i,
  output logic [31:0] m1_data_l_o,
  output logic        m1_load_done_o,
  output logic        m1_store_done_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_be_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic        timeout_o
);

  // Last BUSY cycle value of the watchdog before the transfer is aborted.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_reg;
  state_t            state_next;
  xfer_t             xfer_reg;
  xfer_t             xfer0;
  xfer_t             xfer1;
  xfer_t             win_xfer;
  logic              grant_reg;
  logic              last_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              timeout_reg;
  logic              req0;
  logic              req1;
  logic              gnt_valid;
  logic              gnt_sel;
  logic              xfer_end;
  logic [1:0]        load_done;
  logic [1:0]        store_done;

  // A master requests with either strobe; store takes priority as direction.
  assign req0  = m0_store_i | m0_load_i;
  assign req1  = m1_store_i | m1_load_i;
  assign xfer0 = '{addr: m0_addr_i, data: m0_data_s_i, be: m0_select_i, we: m0_store_i};
  assign xfer1 = '{addr: m1_addr_i, data: m1_data_s_i, be: m1_select_i, we: m1_store_i};
  assign win_xfer = gnt_sel ? xfer1 : xfer0;

  urv_rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .last  (last_reg),
    .valid (gnt_valid),
    .sel   (gnt_sel)
  );

  // The BUSY cycle that ends the transfer, by ack or by watchdog expiry.
  assign xfer_end = (state_reg == ST_BUSY) && (s_ack_i || (cnt_reg == TO_LAST));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; acks outside BUSY are simply not looked at.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (gnt_valid) state_next = ST_BUSY;
      ST_BUSY: if (xfer_end)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Slave request and one-cycle completion strobes decoded from the state.
  always_comb begin
    load_done  = 2'b00;
    store_done = 2'b00;
    s_req_o    = (state_reg == ST_BUSY);
    s_we_o     = (state_reg == ST_BUSY) && xfer_reg.we;
    if (state_reg == ST_DONE) begin
      if (xfer_reg.we) begin
        store_done[grant_reg] = 1'b1;
      end else begin
        load_done[grant_reg] = 1'b1;
      end
    end
  end

  // Transfer latch, grant tracking, watchdog and timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xfer_reg    <= '0;
      grant_reg   <= 1'b0;
      last_reg    <= 1'b1;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= xfer_end && !s_ack_i;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (gnt_valid) begin
            xfer_reg  <= win_xfer;
            grant_reg <= gnt_sel;
          end
        end
        ST_BUSY: cnt_reg <= cnt_reg + CNT_W'(1);
        ST_DONE: begin
          cnt_reg  <= '0;
          last_reg <= grant_reg;
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

  // Per-master load data: only the granted master's register updates, and
  // only for loads, so the other master keeps its last value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dl
    logic [31:0] data_l_reg;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_l_reg <= '0;
      end else if (xfer_end && (grant_reg == 1'(gi)) && !xfer_reg.we) begin
        data_l_reg <= s_ack_i ? s_data_i : ERR_DATA;
      end
    end
  end

  assign m0_data_l_o     = g_dl[0].data_l_reg;
  assign m1_data_l_o     = g_dl[1].data_l_reg;
  assign m0_load_done_o  = load_done[0];
  assign m1_load_done_o  = load_done[1];
  assign m0_store_done_o = store_done[0];
  assign m1_store_done_o = store_done[1];
  assign s_addr_o        = xfer_reg.addr;
  assign s_data_o        = xfer_reg.data;
  assign s_be_o          = xfer_reg.be;
  assign timeout_o       = timeout_reg;

endmodule
